// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register and one-entry skid buffer.
// FETCH_DELAY_SLOT_EN selects delayed-branch redirect; default build squashes on redirect.
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] PC_STEP  = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [7:0]  pc,
    output logic [7:0]  npc,
    output logic [31:0] ifid_instr,
    output logic [7:0]  ifid_pc,
    output logic        ifid_valid
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d, npc_q, npc_d, ifid_pc_q, ifid_pc_d, skid_pc_q, skid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d, skid_instr_q, skid_instr_d;
    logic        ifid_valid_q, ifid_valid_d, drop_q, drop_d, adv;

    assign imem_req   = state_q == REQ;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign npc        = npc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = stall ? ifid_valid_q : 1'b0;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        drop_d       = drop_q;
        adv          = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: if (imem_ack) begin
                drop_d = 1'b0;
                if (!drop_q && stall) begin
                    skid_instr_d = imem_data;
                    skid_pc_d    = pc_q;
                    state_d      = HOLD;
                end else if (!drop_q) begin
                    ifid_instr_d = imem_data;
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = 1'b1;
                    adv          = 1'b1;
                end
            end
            HOLD: if (!stall) begin
                ifid_instr_d = skid_instr_q;
                ifid_pc_d    = skid_pc_q;
                ifid_valid_d = 1'b1;
                adv          = 1'b1;
                state_d      = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            pc_d  = npc_q;
            npc_d = npc_q + PC_STEP;
        end
        if (branch_taken) begin
`ifdef FETCH_DELAY_SLOT_EN
            npc_d = branch_target;
`else
            // an un-acked request is still owed an ack; swallow it before fetching the target
            pc_d         = branch_target;
            npc_d        = branch_target + PC_STEP;
            ifid_valid_d = 1'b0;
            state_d      = REQ;
            drop_d       = state_q == REQ && !imem_ack;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC + PC_STEP;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            drop_q       <= drop_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; fetch handshakes and IF/ID entries
// are matched against queues of expected addresses filled as each scenario is driven.
module tb_fetch_stage;
    logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
    logic [7:0]  branch_target = '0;
    logic        imem_req, ifid_valid;
    logic [7:0]  imem_addr, pc, npc, ifid_pc;
    logic [31:0] imem_data, ifid_instr;
    int          vectors = 0, miscompares = 0;
    logic [7:0]  exp_addr[$], exp_ifid[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc), .npc(npc),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [7:0] a);
        return {8'hC3, a, ~a, 8'h5A};
    endfunction

    assign imem_data = mem(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input bit w);
        exp_addr.push_back(a);
        if (w) exp_ifid.push_back(a);
    endtask

    task automatic cyc(input bit ack, input bit st, input bit br, input logic [7:0] tgt);
        logic [7:0] e;
        imem_ack = ack;
        stall = st;
        branch_taken = br;
        branch_target = tgt;
        #1;
        if (imem_req && ack) begin
            if (exp_addr.size() == 0) check("unexpected_fetch", {24'd0, imem_addr}, 32'hFFFF_FFFF);
            else begin
                e = exp_addr.pop_front();
                check("fetch_addr", {24'd0, imem_addr}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
        if (ifid_valid && !st) begin
            if (exp_ifid.size() == 0) check("unexpected_ifid", {24'd0, ifid_pc}, 32'hFFFF_FFFF);
            else begin
                e = exp_ifid.pop_front();
                check("ifid_pc", {24'd0, ifid_pc}, {24'd0, e});
                check("ifid_instr", ifid_instr, mem(e));
            end
        end
    endtask

    initial begin
        imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_npc", {24'd0, npc}, 32'h04);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_ifid_pc", {24'd0, ifid_pc}, 32'h00);
        check("rst_ifid_instr", ifid_instr, 32'd0);
        reset = 1'b1;
        cyc(1, 0, 0, 8'h00);
        check("idle_ack_ignored", {31'd0, ifid_valid}, 32'd0);
        check("req_after_idle", {31'd0, imem_req}, 32'd1);
        check("first_addr", {24'd0, imem_addr}, 32'h00);
        for (int i = 0; i < 4; i++) begin
            push(8'(i * 4), 1'b1);
            cyc(1, 0, 0, 8'h00);
            check("seq_valid", {31'd0, ifid_valid}, 32'd1);
        end
        check("seq_pc", {24'd0, pc}, 32'h10);
        push(8'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 8'h00);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            check("hold_ifid_pc", {24'd0, ifid_pc}, 32'h0C);
            check("hold_valid", {31'd0, ifid_valid}, 32'd1);
        end
        check("hold_pc", {24'd0, pc}, 32'h10);
        cyc(0, 0, 0, 8'h00);
        check("skid_valid", {31'd0, ifid_valid}, 32'd1);
        check("after_skid_addr", {24'd0, imem_addr}, 32'h14);
        check("after_skid_req", {31'd0, imem_req}, 32'd1);
        cyc(0, 0, 0, 8'h00);
        check("bubble_valid", {31'd0, ifid_valid}, 32'd0);
        check("wait_pc", {24'd0, pc}, 32'h14);
        for (int i = 0; i < 3; i++) begin
            push(8'(8'h14 + i * 4), 1'b1);
            cyc(1, 0, 0, 8'h00);
        end
        check("pc_at_20", {24'd0, pc}, 32'h20);
`ifdef FETCH_DELAY_SLOT_EN
        push(8'h20, 1'b1);
        cyc(1, 0, 1, 8'h40);
        check("ds_pc", {24'd0, pc}, 32'h24);
        check("ds_npc", {24'd0, npc}, 32'h40);
        check("ds_valid0", {31'd0, ifid_valid}, 32'd1);
        push(8'h24, 1'b1);
        cyc(1, 0, 0, 8'h00);
        check("ds_target", {24'd0, pc}, 32'h40);
        check("ds_valid1", {31'd0, ifid_valid}, 32'd1);
        push(8'h40, 1'b1);
        cyc(1, 0, 0, 8'h00);
        push(8'h44, 1'b1);
        cyc(1, 0, 1, 8'hFC);
        push(8'h48, 1'b1);
        cyc(1, 0, 0, 8'h00);
        check("ds_pc_fc", {24'd0, pc}, 32'hFC);
        push(8'hFC, 1'b1);
        cyc(1, 0, 0, 8'h00);
        check("wrap_addr", {24'd0, imem_addr}, 32'h00);
        check("wrap_npc", {24'd0, npc}, 32'h04);
`else
        cyc(0, 0, 1, 8'h40);
        check("sq_valid", {31'd0, ifid_valid}, 32'd0);
        check("sq_addr", {24'd0, imem_addr}, 32'h40);
        push(8'h40, 1'b0);
        cyc(1, 0, 0, 8'h00);
        check("drop_valid", {31'd0, ifid_valid}, 32'd0);
        check("drop_addr", {24'd0, imem_addr}, 32'h40);
        push(8'h40, 1'b1);
        cyc(1, 0, 0, 8'h00);
        push(8'h44, 1'b0);
        cyc(1, 0, 1, 8'hFC);
        check("sq_ack_valid", {31'd0, ifid_valid}, 32'd0);
        check("sq_ack_pc", {24'd0, pc}, 32'hFC);
        push(8'hFC, 1'b1);
        cyc(1, 0, 0, 8'h00);
        check("wrap_addr", {24'd0, imem_addr}, 32'h00);
        check("wrap_npc", {24'd0, npc}, 32'h04);
        push(8'h00, 1'b0);
        cyc(1, 1, 0, 8'h00);
        check("sq_hold_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, 1, 8'h80);
        check("sq_hold_req2", {31'd0, imem_req}, 32'd1);
        check("sq_hold_addr", {24'd0, imem_addr}, 32'h80);
        check("sq_hold_valid", {31'd0, ifid_valid}, 32'd0);
        push(8'h80, 1'b1);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h30);
        cyc(0, 0, 1, 8'h60);
        check("last_wins", {24'd0, pc}, 32'h60);
        push(8'h60, 1'b0);
        cyc(1, 0, 0, 8'h00);
        push(8'h60, 1'b1);
        cyc(1, 0, 0, 8'h00);
        check("last_wins_pc", {24'd0, pc}, 32'h64);
`endif
        imem_ack = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_valid", {31'd0, ifid_valid}, 32'd0);
        check("midrst_pc", {24'd0, pc}, 32'h00);
        check("midrst_npc", {24'd0, npc}, 32'h04);
        @(posedge clk);
        #1;
        check("midrst_nowrite", {31'd0, ifid_valid}, 32'd0);
        check("midrst_instr", ifid_instr, 32'd0);
        check("addr_q_left", exp_addr.size(), 32'd0);
        check("ifid_q_left", exp_ifid.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 8'd4, SHALL be the sequential PC increment.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge except reset.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-005 stall  in  1  SHALL mean decode cannot accept a new IF/ID entry this cycle.
REQ-006 branch_taken  in  1  SHALL request a PC redirect, sampled each rising edge.
REQ-007 branch_target  in  8  SHALL be the redirect address, valid when branch_taken=1.
REQ-008 imem_req  out  1  SHALL request an instruction fetch at imem_addr.
REQ-009 imem_addr  out  8  SHALL equal pc combinationally.
REQ-010 imem_ack  in  1  SHALL mark imem_data valid for the current request, meaningful only while imem_req=1.
REQ-011 imem_data  in  32  SHALL be the fetched instruction word.
REQ-012 pc, npc  out  8 each  SHALL be the current and next program counter registers.
REQ-013 ifid_instr  out  32, ifid_pc  out  8, ifid_valid  out  1  SHALL be the IF/ID pipeline register.

Function
REQ-014 States SHALL be IDLE, REQ and HOLD; imem_req=1 only in REQ.
REQ-015 IDLE SHALL go to REQ on the first rising edge after reset deasserts.
REQ-016 REQ with imem_ack=0 SHALL hold imem_req=1 and pc stable; requests are never abandoned.
REQ-017 REQ, imem_ack=1, stall=0: SHALL load IF/ID with {imem_data, pc, valid=1}, set pc<=npc and npc<=npc+PC_STEP, and stay in REQ.
REQ-018 REQ, imem_ack=1, stall=1: SHALL capture imem_data and pc in a one-entry skid buffer, leave IF/ID and pc unchanged, and go to HOLD.
REQ-019 HOLD, stall=0: SHALL move the skid entry into IF/ID with valid=1, advance pc/npc as in REQ-017, and go to REQ; HOLD with stall=1 SHALL hold everything.
REQ-020 With stall=0 and no IF/ID write that cycle, ifid_valid SHALL go to 0; with stall=1, IF/ID SHALL hold.
REQ-021 PC arithmetic SHALL be modulo 256 (8'hFC + 4 = 8'h00), with no error flag.
REQ-022 Redirect SHALL take priority over stall and sequential advance in the same cycle (behaviour per REQ-027/028).
REQ-023 A second branch_taken before a redirect completes SHALL replace the pending target (last one wins).

Reset
REQ-024 Reset assertion SHALL immediately force pc=RESET_PC, npc=RESET_PC+PC_STEP, state=IDLE, imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, skid buffer empty, and the drop flag clear.
REQ-025 An imem_ack arriving while reset is asserted or during IDLE SHALL be ignored; reset mid-fetch abandons that fetch.

Configuration
REQ-026 Macro FETCH_DELAY_SLOT_EN SHALL select the branch model.
REQ-027 Defined (PA-RISC delayed branch): branch_taken SHALL set npc<=branch_target (overriding any same-cycle increment, while pc<=old npc still occurs if advancing), and SHALL flush nothing, so the delay-slot instruction issues.
REQ-028 Undefined (squash): branch_taken SHALL set pc<=branch_target, npc<=branch_target+PC_STEP, ifid_valid<=0, and empty the skid buffer (HOLD->REQ); if a request is outstanding, its ack SHALL be discarded via a drop flag and the target fetched afterwards.

Verification
REQ-029 Reset low, then high; imem_ack=1 every REQ cycle, stall=0 -> imem_addr 00,04,08,...; ifid_pc trails by one cycle; ifid_valid=1 from the second ack edge.
REQ-030 pc=8'hFC, sequential fetch -> next imem_addr=8'h00 and npc=8'h04.
REQ-031 Ack at pc=10 with stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; stall drops -> ifid_pc=10 and valid=1 for one cycle, then imem_addr=14.
REQ-032 With FETCH_DELAY_SLOT_EN: branch_taken at pc=20, target=40 -> fetch order 20,24,40; ifid_valid never 0 due to the branch.
REQ-033 Without the macro: branch_taken, target=40, while pc=20 has an outstanding ack pending -> ack data dropped, ifid_valid=0, next imem_addr=40.
REQ-034 Reset asserted mid-REQ with imem_ack=1 the same cycle -> imem_req=0 immediately, ifid_valid=0, pc=RESET_PC; no IF/ID write occurs.
